// File: rtl/vga_dac_if.sv
// Video DAC bundle: colour, sync strobes and pixel clock from the display
// timing block (master) to the DAC or an observer (slave).
interface vga_dac_if;
  logic       vsync;
  logic       hsync;
  logic       blank;
  logic       sync;
  logic       vga_clk;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output vsync, hsync, blank, sync, vga_clk, r, g, b);
  modport slave  (input  vsync, hsync, blank, sync, vga_clk, r, g, b);
endinterface

// File: rtl/vector_vga_display_top.sv
// 640x480@60 VGA timing generator with a coordinate test image, an optional
// per-channel inversion stage, and registered DAC outputs at clk/2 pixel rate.
module vector_vga_display_top #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      identity,
  vga_dac_if.master dac
);

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_LAST      = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST      = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t H_VIS       = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS       = cnt_t'(V_VISIBLE);
  localparam cnt_t H_SYNC_BEG  = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t H_SYNC_END  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t V_SYNC_BEG  = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t V_SYNC_END  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       vga_clk_q, vga_clk_d;
  cnt_t       h_count_q, h_count_d;
  cnt_t       v_count_q, v_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_q, blank_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;

  logic       tick;
  logic       visible;
  logic [7:0] r_base, g_base, b_base;

  // A pixel tick is the clk edge on which vga_clk falls, so the DAC sees
  // stable data on every vga_clk rising edge.
  always_comb begin
    tick      = vga_clk_q;
    vga_clk_d = ~vga_clk_q;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_d   = blank_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;

    visible = (h_count_q < H_VIS) && (v_count_q < V_VIS);
    r_base  = h_count_q[7:0];
    g_base  = v_count_q[7:0];
    b_base  = h_count_q[7:0] ^ v_count_q[7:0];
    if (!identity) begin
      r_base = ~r_base;
      g_base = ~g_base;
      b_base = ~b_base;
    end

    if (tick) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
      // Outputs reflect the pre-increment position, one tick late.
      hsync_d = !((h_count_q >= H_SYNC_BEG) && (h_count_q < H_SYNC_END));
      vsync_d = !((v_count_q >= V_SYNC_BEG) && (v_count_q < V_SYNC_END));
      blank_d = visible;
      r_d     = visible ? r_base : 8'd0;
      g_d     = visible ? g_base : 8'd0;
      b_d     = visible ? b_base : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_clk_q <= 1'b0;
      h_count_q <= '0;
      v_count_q <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
    end else begin
      vga_clk_q <= vga_clk_d;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_q   <= blank_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign dac.vga_clk = vga_clk_q;
  assign dac.hsync   = hsync_q;
  assign dac.vsync   = vsync_q;
  assign dac.blank   = blank_q;
  assign dac.sync    = 1'b0;
  assign dac.r       = r_q;
  assign dac.g       = g_q;
  assign dac.b       = b_q;

endmodule

// File: tb/tb_vector_vga_display_top.sv
// Directed bench for vector_vga_display_top: reset values, start-up sequence,
// image/transform values, line and frame timing, and mid-line reset.
`timescale 1ps/1ps
module tb_vector_vga_display_top;

  localparam int H_TOT   = 800;
  localparam int V_VIS   = 4;
  localparam int V_FP    = 2;
  localparam int V_SW    = 2;
  localparam int V_BP    = 2;
  localparam int V_TOT   = V_VIS + V_FP + V_SW + V_BP;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic identity = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_h    = 0;
  int   cur_v    = 0;
  logic cur_id   = 1'b0;
  int   hs_low   = 0;
  int   vs_low   = 0;

  vga_dac_if dac_bus ();

  vector_vga_display_top #(
    .V_VISIBLE (V_VIS),
    .V_FRONT   (V_FP),
    .V_SYNC    (V_SW),
    .V_BACK    (V_BP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .identity (identity),
    .dac      (dac_bus)
  );

  always #2 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".vga_clk"}, dac_bus.vga_clk, 0);
    check_val({tag, ".hsync"},   dac_bus.hsync,   1);
    check_val({tag, ".vsync"},   dac_bus.vsync,   1);
    check_val({tag, ".blank"},   dac_bus.blank,   0);
    check_val({tag, ".sync"},    dac_bus.sync,    0);
    check_val({tag, ".r"},       dac_bus.r,       0);
    check_val({tag, ".g"},       dac_bus.g,       0);
    check_val({tag, ".b"},       dac_bus.b,       0);
  endtask

  // Expected DAC state for the pixel the bench believes is on display.
  task automatic check_model();
    logic [7:0] hb, vb, er, eg, eb;
    logic       vis, ehs, evs;
    string      at;
    at  = $sformatf("@(%0d,%0d)", cur_h, cur_v);
    hb  = 8'(cur_h);
    vb  = 8'(cur_v);
    vis = (cur_h < 640) && (cur_v < V_VIS);
    ehs = !((cur_h >= 656) && (cur_h < 752));
    evs = !((cur_v >= V_VIS + V_FP) && (cur_v < V_VIS + V_FP + V_SW));
    er  = cur_id ? hb : 8'hFF - hb;
    eg  = cur_id ? vb : 8'hFF - vb;
    eb  = cur_id ? (hb ^ vb) : 8'hFF - (hb ^ vb);
    if (!vis) begin
      er = 8'd0;
      eg = 8'd0;
      eb = 8'd0;
    end
    check_val({"hsync", at}, dac_bus.hsync, ehs);
    check_val({"vsync", at}, dac_bus.vsync, evs);
    check_val({"blank", at}, dac_bus.blank, vis);
    check_val({"sync", at},  dac_bus.sync,  0);
    check_val({"r", at},     dac_bus.r,     er);
    check_val({"g", at},     dac_bus.g,     eg);
    check_val({"b", at},     dac_bus.b,     eb);
  endtask

  // Two clk edges per pixel; the second is the tick.
  task automatic next_pixel();
    cur_id = identity;
    @(posedge clk);
    @(posedge clk);
    #1;
    cur_h++;
    if (cur_h == H_TOT) begin
      cur_h = 0;
      cur_v = (cur_v + 1) % V_TOT;
    end
    if (!dac_bus.hsync) hs_low++;
    if (!dac_bus.vsync) vs_low++;
  endtask

  task automatic run_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      next_pixel();
      check_model();
    end
  endtask

  initial begin
    $display("[TB] start");
    reset    = 1'b1;
    identity = 1'b0;
    #11;
    check_reset_state("reset");
    #4;
    reset = 1'b0;

    @(posedge clk); #1;
    check_val("start.edge1.vga_clk", dac_bus.vga_clk, 1);
    check_val("start.edge1.blank",   dac_bus.blank,   0);
    check_val("start.edge1.r",       dac_bus.r,       0);
    @(posedge clk); #1;
    check_val("start.edge2.vga_clk", dac_bus.vga_clk, 0);
    check_val("px0.blank", dac_bus.blank, 1);
    check_val("px0.r",     dac_bus.r,     255);
    check_val("px0.g",     dac_bus.g,     255);
    check_val("px0.b",     dac_bus.b,     255);
    check_val("px0.hsync", dac_bus.hsync, 1);
    check_val("px0.vsync", dac_bus.vsync, 1);
    cur_h  = 0;
    cur_v  = 0;
    cur_id = 1'b0;
    check_model();

    run_pixels(99);
    next_pixel();
    check_val("px100.r", dac_bus.r, 155);
    check_val("px100.g", dac_bus.g, 255);
    check_val("px100.b", dac_bus.b, 155);
    identity = 1'b1;
    next_pixel();
    check_val("px101id.r", dac_bus.r, 101);
    check_val("px101id.g", dac_bus.g, 0);
    check_val("px101id.b", dac_bus.b, 101);
    identity = 1'b0;

    run_pixels(538);
    check_val("px639.blank", dac_bus.blank, 1);
    run_pixels(1);
    check_val("px640.blank", dac_bus.blank, 0);
    check_val("px640.r",     dac_bus.r,     0);
    run_pixels(159);
    check_val("line0.hsync_low_ticks", hs_low, 96);

    next_pixel();
    check_val("line1.px0.blank", dac_bus.blank, 1);
    check_val("line1.px0.r",     dac_bus.r,     255);
    check_val("line1.px0.g",     dac_bus.g,     254);
    check_model();

    run_pixels(299);
    identity = 1'b1;
    next_pixel();
    check_val("px300v1.r", dac_bus.r, 44);
    check_val("px300v1.g", dac_bus.g, 1);
    check_val("px300v1.b", dac_bus.b, 45);
    identity = 1'b0;
    next_pixel();
    check_val("px301v1.r", dac_bus.r, 210);
    check_val("px301v1.g", dac_bus.g, 254);
    check_val("px301v1.b", dac_bus.b, 211);

    vs_low = 0;
    run_pixels(V_TOT * H_TOT - (H_TOT + 302));
    check_val("frame.vsync_low_ticks", vs_low, V_SW * H_TOT);
    check_val("frame.last.blank",      dac_bus.blank, 0);
    next_pixel();
    check_val("frame.wrap.blank", dac_bus.blank, 1);
    check_val("frame.wrap.r",     dac_bus.r,     255);
    check_val("frame.wrap.g",     dac_bus.g,     255);

    identity = 1'b1;
    run_pixels(200);
    reset = 1'b1;
    #1;
    check_reset_state("midreset.async");
    @(posedge clk);
    @(posedge clk); #1;
    check_reset_state("midreset.held");
    identity = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;
    check_val("restart.edge1.vga_clk", dac_bus.vga_clk, 1);
    check_val("restart.edge1.blank",   dac_bus.blank,   0);
    @(posedge clk); #1;
    check_val("restart.px0.vga_clk", dac_bus.vga_clk, 0);
    check_val("restart.px0.blank",   dac_bus.blank,   1);
    check_val("restart.px0.r",       dac_bus.r,       255);
    cur_h  = 0;
    cur_v  = 0;
    cur_id = 1'b0;
    check_model();
    run_pixels(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
